// File: rtl/fsm_mestre_linha_if.sv
// Purpose: groups the sequencer's board inputs, CQ handshake and actuator/display
//          outputs into one bundle.
// Modports:
//   master - the line sequencer (pulses/sensors/CQ status in, actuators/counters out)
//   slave  - the surrounding board logic and station FSMs (mirror directions)
interface fsm_mestre_linha_if;
  logic       pulso_start;
  logic       pulso_parar;
  logic       pulso_reabastecer;
  logic       sensor_posicao;
  logic       sensor_nivel;
  logic       sensor_cq;
  logic       cq_concluida;
  logic       cq_aprovada;
  logic       cq_descarte;
  logic       motor_ativo;
  logic       valvula_ativa;
  logic       vedacao_ativa;
  logic       cmd_verificar;
  logic       alarme_rolhas;
  logic [3:0] cont_garrafas;
  logic [6:0] cont_duzias;
  logic [4:0] rolhas;
  logic [2:0] estado_dbg;

  modport master (
    input  pulso_start, pulso_parar, pulso_reabastecer,
    input  sensor_posicao, sensor_nivel, sensor_cq,
    input  cq_concluida, cq_aprovada, cq_descarte,
    output motor_ativo, valvula_ativa, vedacao_ativa, cmd_verificar, alarme_rolhas,
    output cont_garrafas, cont_duzias, rolhas, estado_dbg
  );

  modport slave (
    output pulso_start, pulso_parar, pulso_reabastecer,
    output sensor_posicao, sensor_nivel, sensor_cq,
    output cq_concluida, cq_aprovada, cq_descarte,
    input  motor_ativo, valvula_ativa, vedacao_ativa, cmd_verificar, alarme_rolhas,
    input  cont_garrafas, cont_duzias, rolhas, estado_dbg
  );
endinterface

// File: rtl/fsm_mestre_linha.sv
// Purpose: master sequencer of one bottling line
//          (conveyor -> filling -> capping -> quality control), counting
//          approved bottles in dozens and tracking the cap magazine.
// Ports:
//   clk     - line clock
//   reset_n - asynchronous reset, active low
//   bus     - fsm_mestre_linha_if.master: 1-cycle operator pulses, station
//             sensors, CQ handshake in; actuators, CQ command, cap alarm,
//             bottle/dozen/cap counters and state code out (all registered).
module fsm_mestre_linha #(
  parameter int unsigned TEMPO_VEDACAO = 50_000_000,
  parameter int unsigned ROLHAS_MAX    = 20,
  parameter int unsigned MAX_DUZIAS    = 99
) (
  input logic                clk,
  input logic                reset_n,
  fsm_mestre_linha_if.master bus
);

  localparam int unsigned TIMER_W = (TEMPO_VEDACAO > 1) ? $clog2(TEMPO_VEDACAO) : 1;
  localparam int unsigned GARR_W  = 4;
  localparam int unsigned DUZ_W   = 7;
  localparam int unsigned ROL_W   = 5;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TEMPO_VEDACAO - 1);
  localparam logic [ROL_W-1:0]   ROL_FULL   = ROL_W'(ROLHAS_MAX);
  localparam logic [GARR_W-1:0]  GARR_LAST  = GARR_W'(11);
  localparam logic [DUZ_W-1:0]   DUZ_MAX    = DUZ_W'(MAX_DUZIAS);

  typedef enum logic [2:0] {
    PARADO   = 3'd0,
    ESTEIRA  = 3'd1,
    ENCHENDO = 3'd2,
    VEDANDO  = 3'd3,
    CQ       = 3'd4,
    FIM      = 3'd5,
    ALARME   = 3'd6
  } estado_t;

  estado_t            estado, estado_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic               stop_pend, stop_pend_nxt;
  logic [ROL_W-1:0]   rolhas_q, rolhas_nxt;
  logic [GARR_W-1:0]  garr_q, garr_nxt;
  logic [DUZ_W-1:0]   duz_q, duz_nxt;
  logic               motor_q, motor_nxt;
  logic               valv_q, valv_nxt;
  logic               ved_q, ved_nxt;
  logic               cmd_q, cmd_nxt;
  logic               alarme_q, alarme_nxt;
  logic               contar;
  logic               gastar_rolha;

  // State register plus registered outputs and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado    <= PARADO;
      timer     <= '0;
      stop_pend <= 1'b0;
      rolhas_q  <= ROL_FULL;
      garr_q    <= '0;
      duz_q     <= '0;
      motor_q   <= 1'b0;
      valv_q    <= 1'b0;
      ved_q     <= 1'b0;
      cmd_q     <= 1'b0;
      alarme_q  <= 1'b0;
    end else begin
      estado    <= estado_nxt;
      timer     <= timer_nxt;
      stop_pend <= stop_pend_nxt;
      rolhas_q  <= rolhas_nxt;
      garr_q    <= garr_nxt;
      duz_q     <= duz_nxt;
      motor_q   <= motor_nxt;
      valv_q    <= valv_nxt;
      ved_q     <= ved_nxt;
      cmd_q     <= cmd_nxt;
      alarme_q  <= alarme_nxt;
    end
  end

  // Next-state, counter updates and output decode of the next state.
  always_comb begin
    estado_nxt    = estado;
    timer_nxt     = '0;
    stop_pend_nxt = stop_pend;
    rolhas_nxt    = rolhas_q;
    garr_nxt      = garr_q;
    duz_nxt       = duz_q;
    contar        = 1'b0;
    gastar_rolha  = 1'b0;
    motor_nxt     = 1'b0;
    valv_nxt      = 1'b0;
    ved_nxt       = 1'b0;
    cmd_nxt       = 1'b0;
    alarme_nxt    = 1'b0;

    // A stop request once a bottle is in progress waits for FIM.
    if (bus.pulso_parar && (estado inside {ENCHENDO, VEDANDO, CQ, FIM, ALARME})) begin
      stop_pend_nxt = 1'b1;
    end

    case (estado)
      PARADO: begin
        if (bus.pulso_start) estado_nxt = ESTEIRA;
      end
      ESTEIRA: begin
        if (bus.pulso_parar)         estado_nxt = PARADO;
        else if (bus.sensor_posicao) estado_nxt = ENCHENDO;
      end
      ENCHENDO: begin
        if (bus.sensor_nivel) begin
          if (rolhas_q == '0) begin
            estado_nxt = ALARME;
          end else begin
            estado_nxt   = VEDANDO;
            gastar_rolha = 1'b1;
          end
        end
      end
      VEDANDO: begin
        if (timer == TIMER_LAST) estado_nxt = CQ;
        else                     timer_nxt  = timer + TIMER_W'(1);
      end
      CQ: begin
        // Discard dominates a simultaneous completion: the bottle is not counted.
        if (bus.cq_descarte) begin
          estado_nxt = FIM;
        end else if (bus.cq_concluida && bus.cq_aprovada) begin
          estado_nxt = FIM;
          contar     = 1'b1;
        end
      end
      FIM: begin
        // A stop arriving in FIM itself also ends the run here.
        estado_nxt = (stop_pend || bus.pulso_parar) ? PARADO : ESTEIRA;
      end
      ALARME: begin
        if (bus.pulso_reabastecer) estado_nxt = VEDANDO;
      end
      default: estado_nxt = PARADO;
    endcase

    if (estado_nxt == PARADO) stop_pend_nxt = 1'b0;

    // Refill outside ALARME wins over a same-cycle cap consumption; in ALARME the
    // refilled magazine immediately supplies the waiting bottle.
    if (bus.pulso_reabastecer) begin
      rolhas_nxt = (estado == ALARME) ? ROL_FULL - ROL_W'(1) : ROL_FULL;
    end else if (gastar_rolha) begin
      rolhas_nxt = rolhas_q - ROL_W'(1);
    end

    // Bottle count wraps every dozen; the dozen count saturates.
    if (contar) begin
      if (garr_q == GARR_LAST) begin
        garr_nxt = '0;
        if (duz_q < DUZ_MAX) duz_nxt = duz_q + DUZ_W'(1);
      end else begin
        garr_nxt = garr_q + GARR_W'(1);
      end
    end

    motor_nxt  = (estado_nxt == ESTEIRA) || ((estado_nxt == CQ) && !bus.sensor_cq);
    valv_nxt   = (estado_nxt == ENCHENDO);
    ved_nxt    = (estado_nxt == VEDANDO);
    cmd_nxt    = (estado_nxt == CQ);
    alarme_nxt = (estado_nxt == ALARME);
  end

  assign bus.motor_ativo   = motor_q;
  assign bus.valvula_ativa = valv_q;
  assign bus.vedacao_ativa = ved_q;
  assign bus.cmd_verificar = cmd_q;
  assign bus.alarme_rolhas = alarme_q;
  assign bus.cont_garrafas = garr_q;
  assign bus.cont_duzias   = duz_q;
  assign bus.rolhas        = rolhas_q;
  assign bus.estado_dbg    = estado;

endmodule

// File: tb/tb_fsm_mestre_linha.sv
// Bench for fsm_mestre_linha: vector table, directed multi-cycle sequences,
// an alarm instance with a 2-cap magazine, and a randomized run against a
// bottle-level reference model.
module tb_fsm_mestre_linha;

  localparam int unsigned TA_T   = 10;
  localparam int unsigned TA_ROL = 20;
  localparam int unsigned TB_T   = 4;
  localparam int unsigned TB_ROL = 2;
  localparam int unsigned MAXD   = 99;

  typedef struct packed {
    logic start, parar, reab, pos, niv, cq, conc, apr, desc;
  } in_t;

  typedef struct packed {
    logic [2:0] est;
    logic       motor, valv, ved, cmd, alarm;
    logic [4:0] rol;
    logic [3:0] garr;
    logic [6:0] duz;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
    int   reps;
  } vec_t;

  //                            s p r pos niv cq conc apr desc
  localparam in_t I_IDLE  = 9'b0_0_0_0_0_0_0_0_0;
  localparam in_t I_START = 9'b1_0_0_0_0_0_0_0_0;
  localparam in_t I_PARAR = 9'b0_1_0_0_0_0_0_0_0;
  localparam in_t I_REAB  = 9'b0_0_1_0_0_0_0_0_0;
  localparam in_t I_POS   = 9'b0_0_0_1_0_0_0_0_0;
  localparam in_t I_NIV   = 9'b0_0_0_0_1_0_0_0_0;
  localparam in_t I_NIVRB = 9'b0_0_1_0_1_0_0_0_0;
  localparam in_t I_CQ    = 9'b0_0_0_0_0_1_0_0_0;
  localparam in_t I_CQST  = 9'b1_0_0_0_0_1_0_0_0;
  localparam in_t I_OKCQ  = 9'b0_0_0_0_0_1_1_1_0;
  localparam in_t I_OK    = 9'b0_0_0_0_0_0_1_1_0;
  localparam in_t I_DESC  = 9'b0_0_0_0_0_0_0_0_1;
  localparam in_t I_BOTH  = 9'b0_0_0_0_0_0_1_1_1;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fsm_mestre_linha_if ifa ();
  fsm_mestre_linha_if ifb ();

  fsm_mestre_linha #(.TEMPO_VEDACAO(TA_T), .ROLHAS_MAX(TA_ROL), .MAX_DUZIAS(MAXD))
    dut_a (.clk(clk), .reset_n(rst_a), .bus(ifa));

  fsm_mestre_linha #(.TEMPO_VEDACAO(TB_T), .ROLHAS_MAX(TB_ROL), .MAX_DUZIAS(MAXD))
    dut_b (.clk(clk), .reset_n(rst_b), .bus(ifb));

  task automatic drive(input bit sel, input in_t v);
    if (sel) begin
      ifb.pulso_start = v.start; ifb.pulso_parar = v.parar; ifb.pulso_reabastecer = v.reab;
      ifb.sensor_posicao = v.pos; ifb.sensor_nivel = v.niv; ifb.sensor_cq = v.cq;
      ifb.cq_concluida = v.conc; ifb.cq_aprovada = v.apr; ifb.cq_descarte = v.desc;
    end else begin
      ifa.pulso_start = v.start; ifa.pulso_parar = v.parar; ifa.pulso_reabastecer = v.reab;
      ifa.sensor_posicao = v.pos; ifa.sensor_nivel = v.niv; ifa.sensor_cq = v.cq;
      ifa.cq_concluida = v.conc; ifa.cq_aprovada = v.apr; ifa.cq_descarte = v.desc;
    end
  endtask

  function automatic out_t sample(input bit sel);
    out_t o;
    if (sel) begin
      o.est = ifb.estado_dbg; o.motor = ifb.motor_ativo; o.valv = ifb.valvula_ativa;
      o.ved = ifb.vedacao_ativa; o.cmd = ifb.cmd_verificar; o.alarm = ifb.alarme_rolhas;
      o.rol = ifb.rolhas; o.garr = ifb.cont_garrafas; o.duz = ifb.cont_duzias;
    end else begin
      o.est = ifa.estado_dbg; o.motor = ifa.motor_ativo; o.valv = ifa.valvula_ativa;
      o.ved = ifa.vedacao_ativa; o.cmd = ifa.cmd_verificar; o.alarm = ifa.alarme_rolhas;
      o.rol = ifa.rolhas; o.garr = ifa.cont_garrafas; o.duz = ifa.cont_duzias;
    end
    return o;
  endfunction

  // flags = {motor, valve, capping, cmd_verificar, alarm}
  function automatic out_t exp_o(input int est, input logic [4:0] flags,
                                 input int rol, input int garr, input int duz);
    out_t o;
    o.est = 3'(est);
    {o.motor, o.valv, o.ved, o.cmd, o.alarm} = flags;
    o.rol = 5'(rol); o.garr = 4'(garr); o.duz = 7'(duz);
    return o;
  endfunction

  function automatic vec_t mkv(input in_t i, input int est, input logic [4:0] flags,
                               input int rol, input int garr, input int reps);
    vec_t v;
    v.i = i; v.o = exp_o(est, flags, rol, garr, 0); v.reps = reps;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bottle from ESTEIRA back to ESTEIRA; optional refill during FIM.
  task automatic bottle(input bit sel, input bit approve, input bit refill);
    int unsigned t;
    t = sel ? TB_T : TA_T;
    drive(sel, I_POS); tick();
    drive(sel, I_NIV); tick();
    drive(sel, I_IDLE);
    repeat (t) tick();
    drive(sel, approve ? I_OK : I_DESC); tick();
    drive(sel, refill ? I_REAB : I_IDLE); tick();
    drive(sel, I_IDLE);
  endtask

  // Bottle-level reference model: phase, remaining capping cycles, caps,
  // total approved bottles (dozen/bottle digits derived arithmetically).
  int m_ph, m_cap_left, m_rol, m_appr;
  bit m_pend, m_mcq;

  task automatic model_reset();
    m_ph = 0; m_cap_left = 0; m_rol = TA_ROL; m_appr = 0; m_pend = 0; m_mcq = 0;
  endtask

  task automatic model_step(input in_t r);
    int  nph;
    bit  use_cap;
    nph = m_ph; use_cap = 0;
    if (r.parar && m_ph >= 2 && m_ph <= 6) m_pend = 1;
    case (m_ph)
      0: if (r.start) nph = 1;
      1: if (r.parar) nph = 0; else if (r.pos) nph = 2;
      2: if (r.niv) begin
           if (m_rol == 0) nph = 6;
           else begin nph = 3; use_cap = 1; m_cap_left = TA_T; end
         end
      3: begin m_cap_left--; if (m_cap_left == 0) nph = 4; end
      4: if (r.desc) nph = 5;
         else if (r.conc && r.apr) begin nph = 5; m_appr++; end
      5: nph = (m_pend || r.parar) ? 0 : 1;
      6: if (r.reab) begin nph = 3; m_cap_left = TA_T; end
      default: nph = 0;
    endcase
    if (r.reab) m_rol = (m_ph == 6) ? TA_ROL - 1 : TA_ROL;
    else if (use_cap) m_rol--;
    if (nph == 0) m_pend = 0;
    if (nph == 4) m_mcq = !r.cq;
    m_ph = nph;
  endtask

  function automatic out_t model_out();
    int d;
    d = m_appr / 12;
    if (d > MAXD) d = MAXD;
    return exp_o(m_ph, {(m_ph == 1) || (m_ph == 4 && m_mcq), m_ph == 2, m_ph == 3,
                        m_ph == 4, m_ph == 6}, m_rol, m_appr % 12, d);
  endfunction

  function automatic in_t rand_in();
    in_t r;
    r.start = ($urandom_range(0, 7) == 0);
    r.parar = ($urandom_range(0, 40) == 0);
    r.reab  = ($urandom_range(0, 150) == 0);
    r.pos   = ($urandom_range(0, 2) == 0);
    r.niv   = ($urandom_range(0, 2) == 0);
    r.cq    = ($urandom_range(0, 1) == 0);
    r.conc  = ($urandom_range(0, 3) == 0);
    r.apr   = ($urandom_range(0, 1) == 0);
    r.desc  = ($urandom_range(0, 9) == 0);
    return r;
  endfunction

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    out_t o;

    drive(0, I_IDLE);
    drive(1, I_IDLE);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", sample(0), exp_o(0, 5'b00000, TA_ROL, 0, 0));
    chk("reset_b", sample(1), exp_o(0, 5'b00000, TB_ROL, 0, 0));
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Main path of one approved bottle, cycle by cycle.
    vecs.push_back(mkv(I_IDLE,  0, 5'b00000, 20, 0, 2));
    vecs.push_back(mkv(I_START, 1, 5'b10000, 20, 0, 1));
    vecs.push_back(mkv(I_IDLE,  1, 5'b10000, 20, 0, 2));
    vecs.push_back(mkv(I_POS,   2, 5'b01000, 20, 0, 1));
    vecs.push_back(mkv(I_IDLE,  2, 5'b01000, 20, 0, 1));
    vecs.push_back(mkv(I_NIV,   3, 5'b00100, 19, 0, 1));
    vecs.push_back(mkv(I_IDLE,  3, 5'b00100, 19, 0, TA_T - 1));
    vecs.push_back(mkv(I_IDLE,  4, 5'b10010, 19, 0, 1));
    vecs.push_back(mkv(I_CQ,    4, 5'b00010, 19, 0, 1));
    vecs.push_back(mkv(I_CQST,  4, 5'b00010, 19, 0, 1));
    vecs.push_back(mkv(I_OKCQ,  5, 5'b00000, 19, 1, 1));
    vecs.push_back(mkv(I_OK,    1, 5'b10000, 19, 1, 1));
    vecs.push_back(mkv(I_IDLE,  1, 5'b10000, 19, 1, 2));
    foreach (vecs[k]) begin
      for (int r = 0; r < vecs[k].reps; r++) begin
        drive(0, vecs[k].i);
        tick();
        chk($sformatf("vec%0d_%0d", k, r), sample(0), vecs[k].o);
      end
    end

    // Discarded bottle: no count, command low in FIM.
    drive(0, I_POS); tick(); drive(0, I_NIV); tick(); drive(0, I_IDLE);
    repeat (TA_T) tick();
    chk("desc_cq", sample(0), exp_o(4, 5'b10010, 18, 1, 0));
    drive(0, I_DESC); tick();
    chk("desc_fim", sample(0), exp_o(5, 5'b00000, 18, 1, 0));
    drive(0, I_IDLE); tick();
    chk("desc_back", sample(0), exp_o(1, 5'b10000, 18, 1, 0));

    // Discard and approved completion in the same cycle: discard wins.
    drive(0, I_POS); tick(); drive(0, I_NIV); tick(); drive(0, I_IDLE);
    repeat (TA_T) tick();
    drive(0, I_BOTH); tick();
    chk("both_fim", sample(0), exp_o(5, 5'b00000, 17, 1, 0));
    drive(0, I_IDLE); tick();
    chk("both_back", sample(0), exp_o(1, 5'b10000, 17, 1, 0));

    // Stop during filling: bottle finishes, line parks at FIM -> PARADO.
    drive(0, I_POS); tick();
    drive(0, I_PARAR); tick();
    chk("stop_fill", sample(0), exp_o(2, 5'b01000, 17, 1, 0));
    drive(0, I_NIV); tick(); drive(0, I_IDLE);
    chk("stop_cap", sample(0), exp_o(3, 5'b00100, 16, 1, 0));
    repeat (TA_T) tick();
    chk("stop_cq", sample(0), exp_o(4, 5'b10010, 16, 1, 0));
    drive(0, I_OK); tick();
    chk("stop_fim", sample(0), exp_o(5, 5'b00000, 16, 2, 0));
    drive(0, I_IDLE); tick();
    chk("stop_parado", sample(0), exp_o(0, 5'b00000, 16, 2, 0));
    tick();
    chk("stop_stays", sample(0), exp_o(0, 5'b00000, 16, 2, 0));

    // Asynchronous reset while capping.
    drive(0, I_START); tick(); drive(0, I_POS); tick(); drive(0, I_NIV); tick();
    drive(0, I_IDLE);
    chk("pre_rst", sample(0), exp_o(3, 5'b00100, 15, 2, 0));
    #1 rst_a = 1'b0;
    #1;
    chk("async_rst", sample(0), exp_o(0, 5'b00000, TA_ROL, 0, 0));
    @(negedge clk);
    rst_a = 1'b1;
    tick();
    chk("post_rst", sample(0), exp_o(0, 5'b00000, TA_ROL, 0, 0));

    // Dozen rollover and saturation.
    drive(0, I_START); tick(); drive(0, I_IDLE);
    repeat (12) bottle(0, 1'b1, 1'b1);
    o = sample(0);
    chk("dozen1", {o.est, o.duz, o.garr}, {3'd1, 7'd1, 4'd0});
    repeat (99 * 12 - 12) bottle(0, 1'b1, 1'b1);
    o = sample(0);
    chk("dozen99", {o.duz, o.garr}, {7'd99, 4'd0});
    repeat (11) bottle(0, 1'b1, 1'b1);
    o = sample(0);
    chk("dozen99_11", {o.duz, o.garr}, {7'd99, 4'd11});
    bottle(0, 1'b1, 1'b1);
    o = sample(0);
    chk("dozen_sat", {o.duz, o.garr}, {7'd99, 4'd0});

    // Two-cap magazine: third bottle raises the alarm.
    drive(1, I_START); tick(); drive(1, I_IDLE);
    bottle(1, 1'b1, 1'b0);
    bottle(1, 1'b1, 1'b0);
    chk("b_empty", sample(1), exp_o(1, 5'b10000, 0, 2, 0));
    drive(1, I_POS); tick(); drive(1, I_NIV); tick(); drive(1, I_IDLE);
    chk("b_alarm", sample(1), exp_o(6, 5'b00001, 0, 2, 0));
    tick();
    chk("b_alarm_hold", sample(1), exp_o(6, 5'b00001, 0, 2, 0));
    drive(1, I_REAB); tick(); drive(1, I_IDLE);
    chk("b_refill", sample(1), exp_o(3, 5'b00100, 1, 2, 0));
    repeat (TB_T) tick();
    chk("b_cq", sample(1), exp_o(4, 5'b10010, 1, 2, 0));
    drive(1, I_OK); tick(); drive(1, I_IDLE); tick();
    chk("b_back", sample(1), exp_o(1, 5'b10000, 1, 3, 0));
    drive(1, I_POS); tick();
    drive(1, I_NIVRB); tick(); drive(1, I_IDLE);
    chk("b_refill_wins", sample(1), exp_o(3, 5'b00100, TB_ROL, 3, 0));

    // Randomized run against the reference model.
    @(negedge clk);
    rst_a = 1'b0;
    drive(0, I_IDLE);
    @(negedge clk);
    rst_a = 1'b1;
    model_reset();
    for (int c = 0; c < 6000; c++) begin
      in_t r;
      r = rand_in();
      drive(0, r);
      @(posedge clk);
      model_step(r);
      #1;
      chk($sformatf("rand%0d", c), sample(0), model_out());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
